// File: rtl/rv_m_pkg.sv
// Shared RV32 M-extension definitions: funct3/funct7 encodings and the
// divider sequencing state type.
package rv_m_pkg;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   localparam logic [6:0] F7_MEXT = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage <-> divider handshake. The core side (master) drives the
// request and operands; the divider (slave) returns the stall, done and result.
interface div_sequencer_if;
   logic        StartE;
   logic        FlushE;
   logic [2:0]  funct3;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        StallDivE;
   logic        DoneE;
   logic [31:0] ResultE;

   modport master (
      output StartE, FlushE, funct3, SrcAE, SrcBE,
      input  StallDivE, DoneE, ResultE
   );

   modport slave (
      input  StartE, FlushE, funct3, SrcAE, SrcBE,
      output StallDivE, DoneE, ResultE
   );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {R,Q} left by one, try to
// subtract the divisor from the partial remainder, keep it if non-negative.
module div_step (
   input  logic [31:0] rIn,
   input  logic [31:0] qIn,
   input  logic [31:0] bIn,
   output logic [31:0] rOut,
   output logic [31:0] qOut
);

   logic [32:0] shifted;
   logic [32:0] trial;

   // Partial remainder stays below the divisor, so the shifted value fits in
   // 33 bits and trial[32] is a reliable sign bit for the subtraction.
   always_comb begin
      shifted = {rIn, qIn[31]};
      trial   = shifted - {1'b0, bIn};
      if (!trial[32]) begin
         rOut = trial[31:0];
         qOut = {qIn[30:0], 1'b1};
      end else begin
         rOut = shifted[31:0];
         qOut = {qIn[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Iterative 32-bit DIV/DIVU/REM/REMU for the Execute stage. Works on operand
// magnitudes, runs 32 restoring steps, then fixes up signs and presents the
// selected result for exactly one cycle while the stall drops.
module div_sequencer
   import rv_m_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   div_sequencer_if.slave     bus
);

   div_state_t  state, stateNext;
   logic [4:0]  count;
   logic [31:0] qReg, rReg, bReg;
   logic        qNeg, rNeg, selRem;
   logic [31:0] resultReg;

   logic        isSigned, aNeg, bNeg;
   logic [31:0] absA, absB;
   logic        divZero, sgnOvf, special, startGo;
   logic [31:0] stepR, stepQ;
   logic [31:0] qFix, rFix;

   // Operand decode at start: magnitudes, sign flags and the two special cases.
   // funct3[2] is always set for divide-class ops; requiring it keeps a stray
   // MUL encoding from ever launching a divide.
   always_comb begin
      isSigned = ~bus.funct3[0];
      aNeg     = isSigned & bus.SrcAE[31];
      bNeg     = isSigned & bus.SrcBE[31];
      absA     = aNeg ? -bus.SrcAE : bus.SrcAE;
      absB     = bNeg ? -bus.SrcBE : bus.SrcBE;
      divZero  = (bus.SrcBE == 32'h0);
      sgnOvf   = isSigned & (bus.SrcAE == 32'h8000_0000) & (bus.SrcBE == 32'hFFFF_FFFF);
      special  = divZero | sgnOvf;
      startGo  = (state == IDLE) & bus.StartE & ~bus.FlushE & bus.funct3[2];
   end

   div_step uStep (
      .rIn  (rReg),
      .qIn  (qReg),
      .bIn  (bReg),
      .rOut (stepR),
      .qOut (stepQ)
   );

   // Sign fix-up applied in FIX; inputs are the unsigned quotient/remainder.
   always_comb begin
      qFix = qNeg ? -qReg : qReg;
      rFix = rNeg ? -rReg : rReg;
   end

   // Next-state logic; flush overrides every transition including DONE->IDLE.
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: if (startGo) stateNext = special ? DONE : CALC;
         CALC: if (count == 5'd31) stateNext = FIX;
         FIX:  stateNext = DONE;
         DONE: stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (bus.FlushE) stateNext = IDLE;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   // Datapath: latch at start, iterate in CALC, fix signs and capture result in FIX.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= 5'd0;
         qReg      <= 32'h0;
         rReg      <= 32'h0;
         bReg      <= 32'h0;
         qNeg      <= 1'b0;
         rNeg      <= 1'b0;
         selRem    <= 1'b0;
         resultReg <= 32'h0;
      end else begin
         unique case (state)
            IDLE: if (startGo) begin
               selRem <= bus.funct3[1];
               qNeg   <= aNeg ^ bNeg;
               rNeg   <= aNeg;
               bReg   <= absB;
               count  <= 5'd0;
               if (divZero) begin
                  qReg      <= 32'hFFFF_FFFF;
                  rReg      <= bus.SrcAE;
                  resultReg <= bus.funct3[1] ? bus.SrcAE : 32'hFFFF_FFFF;
               end else if (sgnOvf) begin
                  qReg      <= 32'h8000_0000;
                  rReg      <= 32'h0;
                  resultReg <= bus.funct3[1] ? 32'h0 : 32'h8000_0000;
               end else begin
                  qReg <= absA;
                  rReg <= 32'h0;
               end
            end
            CALC: if (!bus.FlushE) begin
               qReg  <= stepQ;
               rReg  <= stepR;
               count <= count + 5'd1;
            end
            FIX: if (!bus.FlushE) begin
               qReg      <= qFix;
               rReg      <= rFix;
               resultReg <= selRem ? rFix : qFix;
            end
            default: ;
         endcase
      end
   end

   assign bus.DoneE     = (state == DONE);
   assign bus.ResultE   = resultReg;
   assign bus.StallDivE = ~reset & (startGo | (state == CALC) | (state == FIX));

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed test-plan cases, randomized
// operations against an arithmetic reference model, flush/reset aborts and
// back-to-back issue.
module tb_div_sequencer;
   import rv_m_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   div_sequencer_if bus ();

   div_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: RISC-V divide semantics from plain integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'h0;
      end else if (!f3[0]) begin
         q = sa / sb; r = sa % sb;
      end else begin
         q = a / b; r = a % b;
      end
      return f3[1] ? r : q;
   endfunction

   function automatic bit isSpecial(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Issue one op at cycle 0 and follow it until DoneE (bounded).
   task automatic doDiv(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, output logic [31:0] res, output int doneCyc,
                        output int stallCnt);
      @(negedge clk);
      bus.StartE = 1'b1; bus.funct3 = f3; bus.SrcAE = a; bus.SrcBE = b;
      #1;
      stallCnt = bus.StallDivE ? 1 : 0;
      doneCyc  = -1;
      res      = 32'hx;
      for (int k = 1; k < 60; k++) begin
         @(negedge clk);
         bus.StartE = 1'b0;
         if (scramble) begin bus.SrcAE = $urandom; bus.SrcBE = $urandom; end
         #1;
         if (bus.StallDivE) stallCnt++;
         if (bus.DoneE) begin doneCyc = k; res = bus.ResultE; break; end
      end
   endtask

   task automatic checkOp(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble);
      logic [31:0] res, exp;
      int doneCyc, stallCnt, expLat;
      exp    = model(f3, a, b);
      expLat = isSpecial(f3, a, b) ? 1 : 34;
      doDiv(f3, a, b, scramble, res, doneCyc, stallCnt);
      checks++;
      if (doneCyc < 0) begin
         failures++;
         $display("FAIL %s timeout: no DoneE within 60 cycles", name);
      end else begin
         if (res !== exp) begin
            failures++;
            $display("FAIL %s result f3=%b a=%h b=%h got=%h exp=%h", name, f3, a, b, res, exp);
         end
         checks++;
         if (doneCyc != expLat) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, doneCyc, expLat);
         end
         checks++;
         if (stallCnt != expLat) begin
            failures++;
            $display("FAIL %s stall cycles got=%0d exp=%0d", name, stallCnt, expLat);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.StartE = 1'b1; bus.FlushE = 1'b0; bus.funct3 = F3_DIVU;
      bus.SrcAE = 32'd100; bus.SrcBE = 32'd7;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (bus.StallDivE !== 1'b0) begin
         failures++; $display("FAIL reset_stall got=%b exp=0", bus.StallDivE);
      end
      bus.StartE = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.DoneE !== 1'b0 || bus.ResultE !== 32'h0 || bus.StallDivE !== 1'b0) begin
         failures++;
         $display("FAIL reset_state done=%b result=%h stall=%b exp 0/0/0", bus.DoneE, bus.ResultE, bus.StallDivE);
      end
   endtask

   task automatic test_directed();
      checkOp("divu_100_7", F3_DIVU, 32'd100, 32'd7, 1'b0);
      checkOp("div_m7_2",   F3_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
      checkOp("rem_m7_2",   F3_REM,  32'hFFFF_FFF9, 32'd2, 1'b0);
      checkOp("rem_7_m2",   F3_REM,  32'd7, 32'hFFFF_FFFE, 1'b0);
      checkOp("div_7_m2",   F3_DIV,  32'd7, 32'hFFFF_FFFE, 1'b0);
      checkOp("divu_by0",   F3_DIVU, 32'h1234, 32'h0, 1'b0);
      checkOp("remu_by0",   F3_REMU, 32'h1234, 32'h0, 1'b0);
      checkOp("div_ovf",    F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      checkOp("rem_ovf",    F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      checkOp("divu_max",   F3_DIVU, 32'hFFFF_FFFF, 32'h1, 1'b0);
      checkOp("remu_big",   F3_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      checkOp("operand_change", F3_DIV, 32'h8765_4321, 32'h0000_1357, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         int mode;
         f3   = 3'b100 | 3'($urandom_range(0, 3));
         mode = $urandom_range(0, 9);
         a = $urandom; b = $urandom;
         if (mode == 0) b = 32'h0;
         else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (mode == 2) begin a = $urandom_range(0, 200); b = 32'($signed($urandom_range(0, 20)) - 10); end
         else if (mode == 3) b = $urandom_range(1, 255);
         checkOp("random", f3, a, b, bit'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      bus.StartE = 1'b1; bus.funct3 = F3_DIVU; bus.SrcAE = 32'd100; bus.SrcBE = 32'd7;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.StartE = 1'b0;
      end
      bus.FlushE = 1'b1;
      @(negedge clk);
      bus.FlushE = 1'b0;
      #1;
      checks++;
      if (bus.StallDivE !== 1'b0 || bus.DoneE !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle stall=%b done=%b exp 0/0", bus.StallDivE, bus.DoneE);
      end
      begin
         bit sawDone = 1'b0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (bus.DoneE || bus.StallDivE) sawDone = 1'b1;
         end
         checks++;
         if (sawDone) begin
            failures++; $display("FAIL flush_no_done saw done/stall after flush, exp none");
         end
      end
      checkOp("after_flush_divu_9_3", F3_DIVU, 32'd9, 32'd3, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus.StartE = 1'b1; bus.funct3 = F3_REM; bus.SrcAE = 32'd12345; bus.SrcBE = 32'd77;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         bus.StartE = 1'b0;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.StallDivE !== 1'b0) begin
         failures++; $display("FAIL reset_mid_stall got=%b exp=0", bus.StallDivE);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.DoneE !== 1'b0 || bus.ResultE !== 32'h0 || bus.StallDivE !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_state done=%b result=%h stall=%b exp 0/0/0", bus.DoneE, bus.ResultE, bus.StallDivE);
      end
      begin
         bit sawDone = 1'b0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (bus.DoneE) sawDone = 1'b1;
         end
         checks++;
         if (sawDone) begin
            failures++; $display("FAIL reset_mid_no_done saw DoneE after reset, exp none");
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int doneCyc, stallCnt;
      doDiv(F3_DIV, 32'hFFFF_FC18, 32'd33, 1'b0, res, doneCyc, stallCnt);
      checks++;
      if (doneCyc != 34 || res !== model(F3_DIV, 32'hFFFF_FC18, 32'd33)) begin
         failures++;
         $display("FAIL b2b_first lat=%0d res=%h exp lat=34 res=%h", doneCyc, res, model(F3_DIV, 32'hFFFF_FC18, 32'd33));
      end
      // StartE raised in the DONE cycle must not begin a new op there.
      bus.StartE = 1'b1; bus.funct3 = F3_DIVU; bus.SrcAE = 32'd5; bus.SrcBE = 32'd0;
      checkOp("b2b_second", F3_REMU, 32'd1000, 32'd37, 1'b0);
      checkOp("b2b_third",  F3_DIVU, 32'd1000, 32'd0, 1'b0);
      checkOp("b2b_fourth", F3_REM,  32'hFFFF_FC18, 32'd33, 1'b0);
   endtask

   initial begin
      bus.StartE = 1'b0; bus.FlushE = 1'b0; bus.funct3 = 3'b000;
      bus.SrcAE = 32'h0; bus.SrcBE = 32'h0;
      reset = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
